// File: rtl/pipe_controller.sv
// pipe_controller: pipelined control unit that decodes, checks conditions and carries controls through E/M/W
// Optional feature: define CMP_EN to decode DP cmd 1010 (CMP) as a flag-setting SUB that writes no register.
// Ports: clk, reset (async, active-high); InstrD = instruction[31:12], ALUFlagsE = {N,Z,C,V}, FlushE = E bubble;
//   RegSrcD/ImmSrcD decode selects; ALUSrcE/ALUControlE/BranchTakenE/MemtoRegE execute controls;
//   MemWriteM/RegWriteM memory controls; MemtoRegW/PCSrcW/RegWriteW writeback controls; PCWrPendingF PC write in D/E/M.
module pipe_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] InstrD,
  input  logic [3:0]   ALUFlagsE,
  input  logic         FlushE,
  output logic [1:0]   RegSrcD,
  output logic [1:0]   ImmSrcD,
  output logic         ALUSrcE,
  output logic [2:0]   ALUControlE,
  output logic         BranchTakenE,
  output logic         MemtoRegE,
  output logic         MemWriteM,
  output logic         RegWriteM,
  output logic         MemtoRegW,
  output logic         PCSrcW,
  output logic         RegWriteW,
  output logic         PCWrPendingF
);
  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;
  assign {cond, op, funct} = InstrD[31:20];
  assign cmd = funct[4:1];
  assign rd = InstrD[15:12];
  assign unused_rn = ^InstrD[19:16];
  logic       dp_ok, cmp;
  logic [2:0] dp_alu;
  always_comb begin
    dp_ok = 1'b1;
    cmp = 1'b0;
    dp_alu = 3'b000;
    case (cmd)
      4'b0100: dp_alu = 3'b000;
      4'b0010: dp_alu = 3'b001;
      4'b0000: dp_alu = 3'b010;
      4'b1100: dp_alu = 3'b011;
      4'b0001: dp_alu = 3'b100;
`ifdef CMP_EN
      4'b1010: {dp_alu, cmp} = {3'b001, 1'b1};
`else
`endif
      default: dp_ok = 1'b0;
    endcase
  end
  logic       dp, mem, brn, regw, memw, m2r, alusrc, pcsrc;
  logic [2:0] alu;
  logic [1:0] flagw;
  assign dp = op == 2'b00 && dp_ok;
  assign mem = op == 2'b01;
  assign brn = op == 2'b10;
  assign RegSrcD = brn ? 2'b01 : (mem && !funct[0]) ? 2'b10 : 2'b00;
  assign ImmSrcD = brn ? 2'b10 : mem ? 2'b01 : 2'b00;
  assign alusrc = dp ? funct[5] : mem | brn;
  assign alu = dp ? dp_alu : 3'b000;
  assign regw = (dp & ~cmp) | (mem & funct[0]);
  assign memw = mem & ~funct[0];
  assign m2r = mem & funct[0];
  assign flagw = !dp ? 2'b00 : cmp ? 2'b11 : {funct[0], funct[0] & (cmd == 4'b0100 || cmd == 4'b0010)};
  assign pcsrc = (rd == 4'hf && regw) || brn;
  logic       regw_e_q, memw_e_q, m2r_e_q, pcsrc_e_q, br_e_q, alusrc_e_q;
  logic [2:0] alu_e_q;
  logic [1:0] flagw_e_q;
  logic [3:0] cond_e_q, flags_q, flags_d;
  logic       regw_m_q, memw_m_q, m2r_m_q, pcsrc_m_q, regw_w_q, m2r_w_q, pcsrc_w_q;
  logic       fn, fz, fc, fv, cond_ex;
  assign {fn, fz, fc, fv} = flags_q;
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e_q)
      4'h0: cond_ex = fz;
      4'h1: cond_ex = ~fz;
      4'h2: cond_ex = fc;
      4'h3: cond_ex = ~fc;
      4'h4: cond_ex = fn;
      4'h5: cond_ex = ~fn;
      4'h6: cond_ex = fv;
      4'h7: cond_ex = ~fv;
      4'h8: cond_ex = fc & ~fz;
      4'h9: cond_ex = ~fc | fz;
      4'ha: cond_ex = fn == fv;
      4'hb: cond_ex = fn != fv;
      4'hc: cond_ex = ~fz & (fn == fv);
      4'hd: cond_ex = fz | (fn != fv);
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  assign flags_d = {(flagw_e_q[1] & cond_ex) ? ALUFlagsE[3:2] : flags_q[3:2],
                    (flagw_e_q[0] & cond_ex) ? ALUFlagsE[1:0] : flags_q[1:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {regw_e_q, memw_e_q, pcsrc_e_q, br_e_q, flagw_e_q} <= '0;
      {m2r_e_q, alusrc_e_q, alu_e_q, cond_e_q} <= '0;
      {regw_m_q, memw_m_q, m2r_m_q, pcsrc_m_q} <= '0;
      {regw_w_q, m2r_w_q, pcsrc_w_q} <= '0;
      flags_q <= '0;
    end else begin
      {regw_e_q, memw_e_q, pcsrc_e_q, br_e_q, flagw_e_q} <= FlushE ? '0 : {regw, memw, pcsrc, brn, flagw};
      {m2r_e_q, alusrc_e_q, alu_e_q, cond_e_q} <= {m2r, alusrc, alu, cond};
      {regw_m_q, memw_m_q, m2r_m_q, pcsrc_m_q} <= {regw_e_q & cond_ex, memw_e_q & cond_ex, m2r_e_q,
                                                   pcsrc_e_q & cond_ex & ~br_e_q};
      {regw_w_q, m2r_w_q, pcsrc_w_q} <= {regw_m_q, m2r_m_q, pcsrc_m_q};
      flags_q <= flags_d;
    end
  end
  assign ALUSrcE = alusrc_e_q;
  assign ALUControlE = alu_e_q;
  assign BranchTakenE = br_e_q & cond_ex;
  assign MemtoRegE = m2r_e_q;
  assign MemWriteM = memw_m_q;
  assign RegWriteM = regw_m_q;
  assign MemtoRegW = m2r_w_q;
  assign PCSrcW = pcsrc_w_q;
  assign RegWriteW = regw_w_q;
  assign PCWrPendingF = pcsrc | pcsrc_e_q | pcsrc_m_q;
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: randomized and directed check of pipe_controller against a behavioural pipeline model
module tb_pipe_controller;
  logic        clk = 1'b0, reset = 1'b0, FlushE = 1'b0;
  logic [19:0] InstrD = '0;
  logic [3:0]  ALUFlagsE = '0;
  logic [1:0]  RegSrcD, ImmSrcD;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM, MemtoRegW, PCSrcW, RegWriteW, PCWrPendingF;
  int vectors = 0, miscompares = 0;
  pipe_controller dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .PCWrPendingF(PCWrPendingF)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic regw, memw, m2r, pcsrc, br, alusrc;
    logic [2:0] alu;
    logic [1:0] flagw;
    logic [3:0] cond;
    logic [1:0] regsrc, immsrc;
  } ctl_t;
  localparam logic [3:0] CMD_TAB [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001};
  localparam logic [3:0] PICK [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};
  function automatic ctl_t decode(input logic [19:0] ins);
    ctl_t k;
    logic [3:0] cmd;
    logic s, ok, cmpi;
    k = '0;
    cmd = ins[12:9];
    s = ins[8];
    ok = 1'b0;
    cmpi = 1'b0;
    k.cond = ins[19:16];
    if (ins[15:14] == 2'b00) begin
      for (int j = 0; j < 5; j++) if (cmd == CMD_TAB[j]) begin ok = 1'b1; k.alu = 3'(j); end
`ifdef CMP_EN
      if (cmd == 4'b1010) begin ok = 1'b1; cmpi = 1'b1; k.alu = 3'd1; end
`endif
      if (ok) begin
        k.alusrc = ins[13];
        k.regw = !cmpi;
        k.flagw = cmpi ? 2'b11 : {s, s && k.alu <= 3'd1};
      end
    end else if (ins[15:14] == 2'b01) begin
      k.regsrc = s ? 2'b00 : 2'b10;
      k.immsrc = 2'b01;
      k.alusrc = 1'b1;
      k.m2r = s;
      k.regw = s;
      k.memw = !s;
    end else if (ins[15:14] == 2'b10) begin
      k.regsrc = 2'b01;
      k.immsrc = 2'b10;
      k.alusrc = 1'b1;
      k.br = 1'b1;
    end
    k.pcsrc = (ins[3:0] == 4'hf && k.regw) || k.br;
    return k;
  endfunction
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] && !f[2];
      3'd5: b = f[3] == f[0];
      3'd6: b = !f[2] && f[3] == f[0];
      default: b = 1'b0;
    endcase
    return c == 4'hf ? 1'b0 : c == 4'he ? 1'b1 : b ^ c[0];
  endfunction
  function automatic logic [3:0] new_flags(input ctl_t e, input logic [3:0] f, input logic [3:0] alu_f);
    logic ce;
    ce = cond_holds(e.cond, f);
    return {(e.flagw[1] && ce) ? alu_f[3:2] : f[3:2], (e.flagw[0] && ce) ? alu_f[1:0] : f[1:0]};
  endfunction
  function automatic ctl_t retire(input ctl_t e, input logic [3:0] f);
    ctl_t m;
    logic ce;
    ce = cond_holds(e.cond, f);
    m = '0;
    m.regw = e.regw && ce;
    m.memw = e.memw && ce;
    m.m2r = e.m2r;
    m.pcsrc = e.pcsrc && ce && !e.br;
    return m;
  endfunction
  function automatic ctl_t enter(input ctl_t d, input logic fe);
    ctl_t e;
    e = d;
    if (fe) {e.regw, e.memw, e.pcsrc, e.br, e.flagw} = '0;
    return e;
  endfunction
  ctl_t me = '0, mm = '0, mw = '0;
  logic [3:0] mf = '0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      me <= '0; mm <= '0; mw <= '0; mf <= '0;
    end else begin
      mf <= new_flags(me, mf, ALUFlagsE);
      mw <= mm;
      mm <= retire(me, mf);
      me <= enter(decode(InstrD), FlushE);
    end
  end
  always @(negedge clk) begin
    logic [15:0] act, exp;
    ctl_t d;
    #2;
    d = decode(InstrD);
    exp = {d.regsrc, d.immsrc, me.alusrc, me.alu, me.br && cond_holds(me.cond, mf), me.m2r,
           mm.memw, mm.regw, mw.m2r, mw.pcsrc, mw.regw, d.pcsrc || me.pcsrc || mm.pcsrc};
    act = {RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE,
           MemWriteM, RegWriteM, MemtoRegW, PCSrcW, RegWriteW, PCWrPendingF};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t instr=%h got %h expected %h", $time, InstrD, act, exp);
    end
  end
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic step(input logic [19:0] ins, input logic [3:0] fl = 4'h0, input logic fe = 1'b0, input logic r = 1'b0);
    @(negedge clk);
    InstrD = ins; ALUFlagsE = fl; FlushE = fe; reset = r;
    #3;
  endtask
  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    return {c, op, f, 4'h0, rd};
  endfunction
  localparam logic [19:0] FILL  = {4'he, 2'b11, 6'b000000, 4'h0, 4'h0};
  localparam logic [19:0] ADDS  = {4'he, 2'b00, 6'b001001, 4'h0, 4'h1};
  localparam logic [19:0] BEQ   = {4'h0, 2'b10, 6'b100000, 4'h0, 4'h0};
  initial begin
    logic [3:0] cm;
    logic [19:0] ins;
    #1 reset = 1'b1;
    #2 chk("reset_regs", {RegWriteW, MemWriteM, PCSrcW, RegWriteM, MemtoRegW, BranchTakenE, ALUControlE == 3'd0}, 8'h01);
    step(FILL); step(FILL);
    step(ADDS); step(BEQ, 4'b0100); step(FILL);
    chk("beq_taken", BranchTakenE, 1);
    step(ADDS); step(BEQ, 4'b0000); step(FILL);
    chk("beq_not_taken", BranchTakenE, 0);
    step(mk(4'he, 2'b01, 6'b011000, 4'h3));
    chk("str_immsrc", ImmSrcD, 1);
    step(FILL);
    chk("str_aluctl", ALUControlE, 0);
    chk("str_memw_early", MemWriteM, 0);
    step(FILL);
    chk("str_memw", MemWriteM, 1);
    step(FILL);
    chk("str_regw_w", RegWriteW, 0);
    step(mk(4'he, 2'b00, 6'b001000, 4'hf));
    chk("pc_pend_d", PCWrPendingF, 1);
    step(FILL); chk("pc_pend_e", PCWrPendingF, 1);
    step(FILL); chk("pc_pend_m", PCWrPendingF, 1);
    step(FILL); chk("pcsrc_w", PCSrcW, 1); chk("pc_pend_clear", PCWrPendingF, 0);
    step(mk(4'he, 2'b00, 6'b001000, 4'hf), 4'h0, 1'b1);
    step(FILL); chk("pc_pend_flushed", PCWrPendingF, 0);
    step(FILL); step(FILL); chk("pcsrc_w_flushed", PCSrcW, 0);
    step(ADDS); step(mk(4'he, 2'b00, 6'b010101, 4'h0), 4'b0100); step(FILL, 4'b0000); step(BEQ);
    chk("cmp_memw", MemWriteM, 0);
    step(FILL);
    chk("cmp_regw_w", RegWriteW, 0);
`ifdef CMP_EN
    chk("cmp_flags", BranchTakenE, 0);
`else
    chk("cmp_flags", BranchTakenE, 1);
`endif
    step(mk(4'he, 2'b00, 6'b000101, 4'h0)); step(FILL); step(FILL); step(FILL);
    chk("subs_regw_w", RegWriteW, 1);
    step(ADDS); step(mk(4'hf, 2'b00, 6'b001001, 4'h2), 4'b0100); step(FILL, 4'b0000); step(BEQ);
    chk("nv_regw_m", RegWriteM, 0);
    step(FILL);
    chk("nv_flags", BranchTakenE, 1);
    step(ADDS); step(mk(4'hb, 2'b00, 6'b001000, 4'h2), 4'b1000); step(FILL); step(FILL);
    chk("lt_regw_m", RegWriteM, 1);
    step(ADDS); step(mk(4'he, 2'b01, 6'b011001, 4'h2), 4'b0100); step(FILL); step(FILL);
    chk("ldr_regw_m", RegWriteM, 1);
    step(FILL);
    chk("ldr_regw_w", RegWriteW, 1);
    chk("ldr_m2r_w", MemtoRegW, 1);
    reset = 1'b1;
    #1 chk("reset_now", {RegWriteW, MemWriteM, PCSrcW, RegWriteM, MemtoRegW}, 0);
    step(FILL, 4'h0, 1'b0, 1'b1); chk("reset_hold", RegWriteW, 0);
    step(BEQ); chk("reset_release", RegWriteW, 0);
    step(FILL); chk("reset_flags", BranchTakenE, 0); chk("reset_regw_w", RegWriteW, 0);
    for (int i = 0; i < 3000; i++) begin
      cm = $urandom_range(0, 1) ? PICK[$urandom_range(0, 5)] : 4'($urandom);
      ins = mk($urandom_range(0, 1) ? 4'he : 4'($urandom), 2'($urandom),
               {1'($urandom), cm, 1'($urandom)}, ($urandom_range(0, 7) == 0) ? 4'hf : 4'($urandom));
      ins[7:4] = 4'($urandom);
      step(ins, 4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
